rx_mem_reader: RTL and testbench

Wishbone-side read controller for the 1 KiB receive packet SRAM (`sky130_sram_1kbyte_1rw1r_8x1024_8`, read port 1). It turns 32-bit Wishbone reads of the packet window into four sequenced byte reads on the SRAM read port and packs the bytes little-endian. It also provides a status/control register pair that tracks buffer ownership between the MAC receive path and the PicoRV firmware, and it drives the receive interrupt. It sits in `user_project_wrapper` between the Wishbone slave bus and the SRAM `clk1/csb1/addr1/dout1` port.

---
 rtl/rx_mem_pkg.sv | 38 +++
 rtl/rx_buf_owner.sv | 55 +++++
 rtl/rx_mem_reader.sv | 186 ++++++++++++++++++
 tb/tb_rx_mem_reader.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_mem_pkg.sv
// Shared types and constants for the receive-buffer Wishbone reader.
package rx_mem_pkg;

    localparam int unsigned SRAM_DEPTH = 1024;
    localparam int unsigned SRAM_DW    = 8;
    localparam int unsigned SRAM_AW    = $clog2(SRAM_DEPTH);
    localparam int unsigned LEN_W      = 11;
    localparam int unsigned LANES      = 4;

    localparam logic [11:0] RX_WIN_END = 12'h3FF;
    localparam logic [11:0] RX_STATUS  = 12'h400;
    localparam logic [11:0] RX_CTRL    = 12'h404;

    localparam int unsigned ST_READY_BIT     = 0;
    localparam int unsigned ST_OVERRUN_BIT   = 1;
    localparam int unsigned ST_LEN_LSB       = 16;
    localparam int unsigned CTRL_RELEASE_BIT = 0;
    localparam int unsigned CTRL_CLR_OVR_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_ACK  = 2'd2
    } rx_state_e;

    // Lowest set lane of a non-empty mask.
    function automatic logic [1:0] first_lane(input logic [LANES-1:0] mask);
        first_lane = 2'd0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) first_lane = 2'(i);
        end
    endfunction

    function automatic logic [LANES-1:0] lane_onehot(input logic [1:0] lane);
        lane_onehot = LANES'(4'b0001 << lane);
    endfunction

endpackage

// File: rtl/rx_buf_owner.sv
// Buffer ownership between MAC and firmware: ready/overrun/len and release pulse.
module rx_buf_owner
    import rx_mem_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_frame_done,
    input  logic [LEN_W-1:0] i_frame_len,
    input  logic             i_release,
    input  logic             i_clr_ovr,
    output logic             o_ready,
    output logic             o_overrun,
    output logic [LEN_W-1:0] o_len,
    output logic             o_release
);

    logic             r_ready;
    logic             r_overrun;
    logic [LEN_W-1:0] r_len;
    logic             r_release;
    logic             w_set_ovr;
    logic             w_rel_eff;

    // A release coinciding with a new frame hands the buffer straight back to firmware.
    assign w_set_ovr = i_frame_done & r_ready & ~i_release;
    assign w_rel_eff = i_release & r_ready & ~i_frame_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_len     <= '0;
            r_release <= 1'b0;
        end else begin
            if (i_frame_done && !w_set_ovr) begin
                r_ready <= 1'b1;
                r_len   <= i_frame_len;
            end else if (w_rel_eff) begin
                r_ready <= 1'b0;
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                r_overrun <= 1'b0;
            end
            r_release <= w_rel_eff;
        end
    end

    assign o_ready   = r_ready;
    assign o_overrun = r_overrun;
    assign o_len     = r_len;
    assign o_release = r_release;

endmodule

// File: rtl/rx_mem_reader.sv
// Wishbone reader for the 1 KiB receive SRAM plus STATUS/CTRL and rx interrupt.
// Optional RX_MEM_READER_BYTESEL_EN: window reads fetch only the lanes in wbs_sel_i.
module rx_mem_reader
    import rx_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic               wbs_ack_o,
    output logic [31:0]        wbs_dat_o,
    output logic               csb1,
    output logic [SRAM_AW-1:0] addr1,
    input  logic [SRAM_DW-1:0] dout1,
    input  logic               rx_frame_done,
    input  logic [LEN_W-1:0]   rx_frame_len,
    output logic               buf_busy,
    output logic               buf_release,
    output logic               rx_irq
);

    rx_state_e                      r_state, w_state_n;
    logic                           r_ack, w_ack_n;
    logic [31:0]                    r_dat, w_dat_n;
    logic                           r_csb1, w_csb1_n;
    logic [SRAM_AW-1:0]             r_addr1, w_addr1_n;
    logic [LANES-1:0]               r_todo, w_todo_n;
    logic                           r_iss_last, w_iss_last_n;
    logic [7:0]                     r_word, w_word_n;
    logic [LANES-1:0][SRAM_DW-1:0]  r_lanes, w_lanes_n;
    logic [RD_LAT-1:0]              r_pv, r_plast;
    logic [RD_LAT-1:0][1:0]         r_plane;

    logic             w_hit, w_req, w_win, w_cap, w_cap_last;
    logic [1:0]       w_cap_lane, w_lane;
    logic [11:0]      w_off;
    logic [LANES-1:0] w_mask;
    logic [31:0]      w_status;
    logic             w_rel_req, w_clr_req;
    logic             w_ready, w_overrun;
    logic [LEN_W-1:0] w_len;
    logic             w_unused;

    assign w_hit  = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign w_req  = wbs_stb_i & wbs_cyc_i & w_hit;
    assign w_win  = (wbs_adr_i[11:0] <= RX_WIN_END);
    assign w_off  = {wbs_adr_i[11:2], 2'b00};
    assign w_unused = ^{wbs_dat_i[31:2], wbs_sel_i[3:1]};

`ifdef RX_MEM_READER_BYTESEL_EN
    assign w_mask = wbs_sel_i;
`else
    assign w_mask = 4'hF;
`endif

    // Oldest pipeline stage holds the issue whose data is on dout1 this edge.
    assign w_cap      = (r_state == ST_RD) && r_pv[RD_LAT-1];
    assign w_cap_last = r_plast[RD_LAT-1];
    assign w_cap_lane = r_plane[RD_LAT-1];

    always_comb begin
        w_status                            = '0;
        w_status[ST_READY_BIT]              = w_ready;
        w_status[ST_OVERRUN_BIT]            = w_overrun;
        w_status[ST_LEN_LSB +: LEN_W]       = w_len;
    end

    always_comb begin
        w_state_n    = r_state;
        w_ack_n      = 1'b0;
        w_dat_n      = r_dat;
        w_csb1_n     = 1'b1;
        w_addr1_n    = r_addr1;
        w_todo_n     = r_todo;
        w_iss_last_n = r_iss_last;
        w_word_n     = r_word;
        w_lanes_n    = r_lanes;
        w_lane       = 2'd0;
        w_rel_req    = 1'b0;
        w_clr_req    = 1'b0;
        if (w_cap) w_lanes_n[w_cap_lane] = dout1;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    if (w_win && !wbs_we_i && (w_mask != 4'h0)) begin
                        w_state_n    = ST_RD;
                        w_lane       = first_lane(w_mask);
                        w_csb1_n     = 1'b0;
                        w_addr1_n    = {wbs_adr_i[9:2], w_lane};
                        w_todo_n     = w_mask & ~lane_onehot(w_lane);
                        w_iss_last_n = (w_todo_n == 4'h0);
                        w_word_n     = wbs_adr_i[9:2];
                        w_lanes_n    = '0;
                    end else begin
                        w_state_n = ST_ACK;
                        w_ack_n   = 1'b1;
                        w_dat_n   = (!wbs_we_i && w_off == RX_STATUS) ? w_status : 32'h0;
                        w_rel_req = wbs_we_i && (w_off == RX_CTRL) && wbs_sel_i[0]
                                    && wbs_dat_i[CTRL_RELEASE_BIT];
                        w_clr_req = wbs_we_i && (w_off == RX_CTRL) && wbs_sel_i[0]
                                    && wbs_dat_i[CTRL_CLR_OVR_BIT];
                    end
                end
            end
            ST_RD: begin
                if (r_todo != 4'h0) begin
                    w_lane       = first_lane(r_todo);
                    w_csb1_n     = 1'b0;
                    w_addr1_n    = {r_word, w_lane};
                    w_todo_n     = r_todo & ~lane_onehot(w_lane);
                    w_iss_last_n = (w_todo_n == 4'h0);
                end
                if (w_cap && w_cap_last) begin
                    w_state_n = ST_ACK;
                    w_ack_n   = 1'b1;
                    w_dat_n   = w_lanes_n;
                end
            end
            ST_ACK:  w_state_n = ST_IDLE;
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            r_state    <= ST_IDLE;
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_csb1     <= 1'b1;
            r_addr1    <= '0;
            r_todo     <= '0;
            r_iss_last <= 1'b0;
            r_word     <= '0;
            r_lanes    <= '0;
            r_pv       <= '0;
            r_plast    <= '0;
            r_plane    <= '0;
        end else begin
            r_state    <= w_state_n;
            r_ack      <= w_ack_n;
            r_dat      <= w_dat_n;
            r_csb1     <= w_csb1_n;
            r_addr1    <= w_addr1_n;
            r_todo     <= w_todo_n;
            r_iss_last <= w_iss_last_n;
            r_word     <= w_word_n;
            r_lanes    <= w_lanes_n;
            for (int k = RD_LAT - 1; k > 0; k--) begin
                r_pv[k]    <= r_pv[k-1];
                r_plast[k] <= r_plast[k-1];
                r_plane[k] <= r_plane[k-1];
            end
            r_pv[0]    <= ~r_csb1;
            r_plast[0] <= r_iss_last;
            r_plane[0] <= r_addr1[1:0];
        end
    end

    rx_buf_owner u_owner (
        .clk          (wb_clk_i),
        .rst_n        (wb_rst_n),
        .i_frame_done (rx_frame_done),
        .i_frame_len  (rx_frame_len),
        .i_release    (w_rel_req),
        .i_clr_ovr    (w_clr_req),
        .o_ready      (w_ready),
        .o_overrun    (w_overrun),
        .o_len        (w_len),
        .o_release    (buf_release)
    );

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;
    assign csb1      = r_csb1;
    assign addr1     = r_addr1;
    assign buf_busy  = w_ready;
    assign rx_irq    = w_ready;

endmodule

// File: tb/tb_rx_mem_reader.sv
// Randomized bench for rx_mem_reader against a transaction-level model of the SRAM and status logic.
`timescale 1ns/1ps
module tb_rx_mem_reader;

    localparam int RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
    logic [3:0]  wbs_sel_i = 4'h0;
    logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic        csb1;
    logic [9:0]  addr1;
    logic [7:0]  dout1 = '0;
    logic        rx_frame_done = 1'b0;
    logic [10:0] rx_frame_len = '0;
    logic        buf_busy, buf_release, rx_irq;

    rx_mem_reader #(.BASE_ADDR(32'h3000_0000), .RD_LAT(RD_LAT)) dut (
        .wb_clk_i(clk), .wb_rst_n(rst_n),
        .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .csb1(csb1), .addr1(addr1), .dout1(dout1),
        .rx_frame_done(rx_frame_done), .rx_frame_len(rx_frame_len),
        .buf_busy(buf_busy), .buf_release(buf_release), .rx_irq(rx_irq)
    );

    always #5 clk = ~clk;

    // SRAM read port: one-cycle latency, garbage when deselected.
    logic [7:0] mem [1024];
    always @(posedge clk) dout1 <= csb1 ? 8'($urandom) : mem[addr1];

    int          checks = 0;
    int          errors = 0;
    bit          m_ready, m_ovr, m_rel_pulse, m_ctrl_rel, m_ctrl_clr, rand_fd, rel_seen;
    logic [10:0] m_len;
    int          cyc_in;
    int          sram_idx[$];
    logic [9:0]  sram_adr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update model at the edge, compare DUT mid-cycle.
    task automatic tick();
        bit old, set_ovr;
        @(posedge clk);
        if (!rst_n) begin
            m_ready = 0; m_ovr = 0; m_len = '0; m_rel_pulse = 0;
        end else begin
            old         = m_ready;
            set_ovr     = rx_frame_done && old && !m_ctrl_rel;
            m_rel_pulse = !rx_frame_done && m_ctrl_rel && old;
            if (rx_frame_done && !set_ovr) begin
                m_ready = 1; m_len = rx_frame_len;
            end else if (m_rel_pulse) begin
                m_ready = 0;
            end
            if (set_ovr) m_ovr = 1;
            else if (m_ctrl_clr) m_ovr = 0;
        end
        @(negedge clk);
        cyc_in++;
        if (csb1 === 1'b0) begin
            sram_idx.push_back(cyc_in);
            sram_adr.push_back(addr1);
        end
        if (buf_release === 1'b1) rel_seen = 1;
        chk("rx_irq", 32'(rx_irq), 32'(m_ready));
        chk("buf_busy", 32'(buf_busy), 32'(m_ready));
        chk("buf_release", 32'(buf_release), 32'(m_rel_pulse));
        if (rand_fd) begin
            rx_frame_done = ($urandom_range(0, 5) == 0);
            rx_frame_len  = 11'($urandom);
        end else begin
            rx_frame_done = 1'b0;
        end
    endtask

    task automatic wb_xfer(input logic [31:0] adr, input bit we, input logic [31:0] wdat,
                           input logic [3:0] sel, input bit fd, input logic [10:0] fd_len,
                           output logic [31:0] rdat, output int lat);
        bit          page, win;
        logic [11:0] off;
        logic [3:0]  mask;
        logic [31:0] exp_d;
        int          n, exp_lat, k;
        page = (adr[31:12] == 20'h30000);
        off  = {adr[11:2], 2'b00};
        win  = page && (adr[11:10] == 2'b00);
        mask = 4'hF;
`ifdef RX_MEM_READER_BYTESEL_EN
        mask = sel;
`endif
        if (!(win && !we)) mask = 4'h0;
        n = $countones(mask);
        exp_d = '0;
        if (win && !we) begin
            for (int i = 0; i < 4; i++)
                if (mask[i]) exp_d[8*i +: 8] = mem[{adr[9:2], 2'(i)}];
        end else if (!we && off == 12'h400) begin
            exp_d = {5'b0, m_len, 14'b0, m_ovr, m_ready};
        end
        exp_lat = (n == 0) ? 1 : 1 + n + RD_LAT;
        wbs_adr_i = adr; wbs_we_i = we; wbs_dat_i = wdat; wbs_sel_i = sel;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        if (fd) begin rx_frame_done = 1'b1; rx_frame_len = fd_len; end
        m_ctrl_rel = page && we && off == 12'h404 && sel[0] && wdat[0];
        m_ctrl_clr = page && we && off == 12'h404 && sel[0] && wdat[1];
        sram_idx.delete(); sram_adr.delete();
        cyc_in = 0; lat = 0; rdat = '0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            m_ctrl_rel = 0; m_ctrl_clr = 0;
            if (wbs_ack_o === 1'b1) begin lat = i; rdat = wbs_dat_o; break; end
        end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
        chk("ack_latency", 32'(lat), 32'(exp_lat));
        if (!we) chk("read_data", rdat, exp_d);
        chk("sram_reads", 32'(sram_idx.size()), 32'(n));
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (k < sram_idx.size()) begin
                    chk("sram_addr", 32'(sram_adr[k]), 32'({adr[9:2], 2'(i)}));
                    chk("sram_cycle", 32'(sram_idx[k]), 32'(k + 1));
                end
                k++;
            end
        end
        tick();
        chk("ack_one_cycle", 32'(wbs_ack_o), 32'd0);
    endtask

    initial begin
        logic [31:0] d;
        int          lat, acks, r;
        logic [31:0] a;
        m_ready = 0; m_ovr = 0; m_len = '0; m_rel_pulse = 0;
        m_ctrl_rel = 0; m_ctrl_clr = 0; rand_fd = 0; rel_seen = 0; cyc_in = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[16] = 8'h11; mem[17] = 8'h22; mem[18] = 8'h33; mem[19] = 8'h44;

        repeat (3) tick();
        chk("rst_ack", 32'(wbs_ack_o), 32'd0);
        chk("rst_dat", wbs_dat_o, 32'd0);
        chk("rst_csb1", 32'(csb1), 32'd1);
        chk("rst_addr1", 32'(addr1), 32'd0);
        chk("rst_busy", 32'(buf_busy), 32'd0);
        chk("rst_release", 32'(buf_release), 32'd0);
        chk("rst_irq", 32'(rx_irq), 32'd0);
        rst_n = 1'b1;
        tick();

        wb_xfer(32'h3000_0010, 0, 0, 4'hF, 0, 0, d, lat);
        chk("win_data_lit", d, 32'h4433_2211);
        chk("win_lat_lit", 32'(lat), 32'd6);

        rx_frame_done = 1'b1; rx_frame_len = 11'd64;
        tick();
        chk("irq_after_frame", 32'(rx_irq), 32'd1);
        wb_xfer(32'h3000_0400, 0, 0, 4'hF, 0, 0, d, lat);
        chk("status_lit", d, 32'h0040_0001);
        rel_seen = 0;
        wb_xfer(32'h3000_0404, 1, 32'h1, 4'hF, 0, 0, d, lat);
        chk("release_pulse_lit", 32'(rel_seen), 32'd1);
        chk("irq_after_release", 32'(rx_irq), 32'd0);

        rx_frame_done = 1'b1; rx_frame_len = 11'd64; tick();
        rx_frame_done = 1'b1; rx_frame_len = 11'd99; tick();
        wb_xfer(32'h3000_0400, 0, 0, 4'hF, 0, 0, d, lat);
        chk("status_overrun_lit", d, 32'h0040_0003);
        wb_xfer(32'h3000_0404, 1, 32'h2, 4'hF, 0, 0, d, lat);
        wb_xfer(32'h3000_0400, 0, 0, 4'hF, 0, 0, d, lat);
        chk("status_clr_ovr_lit", d, 32'h0040_0001);

        rel_seen = 0;
        wb_xfer(32'h3000_0404, 1, 32'h1, 4'hF, 1, 11'd20, d, lat);
        chk("same_cycle_no_release", 32'(rel_seen), 32'd0);
        wb_xfer(32'h3000_0400, 0, 0, 4'hF, 0, 0, d, lat);
        chk("status_same_cycle_lit", d, 32'h0014_0001);

        // Off-page access must never be acknowledged.
        wbs_adr_i = 32'h3000_1000; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        sram_idx.delete(); sram_adr.delete(); acks = 0;
        repeat (20) begin tick(); if (wbs_ack_o === 1'b1) acks++; end
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        tick();
        chk("offpage_acks", 32'(acks), 32'd0);
        chk("offpage_sram", 32'(sram_idx.size()), 32'd0);

        // Reset in cycle T3 of a window read.
        wbs_adr_i = 32'h3000_0020; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
        repeat (3) tick();
        chk("midread_csb1_low", 32'(csb1), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_csb1", 32'(csb1), 32'd1);
        chk("midrst_ack", 32'(wbs_ack_o), 32'd0);
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        acks = 0;
        repeat (8) begin tick(); if (wbs_ack_o === 1'b1) acks++; end
        chk("midrst_no_ack", 32'(acks), 32'd0);
        wb_xfer(32'h3000_0010, 0, 0, 4'hF, 0, 0, d, lat);
        chk("post_rst_data_lit", d, 32'h4433_2211);

`ifdef RX_MEM_READER_BYTESEL_EN
        wb_xfer(32'h3000_0010, 0, 0, 4'b0100, 0, 0, d, lat);
        chk("bytesel_data_lit", d, 32'h0033_0000);
        chk("bytesel_lat_lit", 32'(lat), 32'd3);
        chk("bytesel_addr_lit", (sram_adr.size() > 0) ? 32'(sram_adr[0]) : 32'hFFFF, 32'h12);
        wb_xfer(32'h3000_0010, 0, 0, 4'b0000, 0, 0, d, lat);
        chk("sel0_lat_lit", 32'(lat), 32'd1);
`endif

        rand_fd = 1;
        for (int t = 0; t < 150; t++) begin
            r = $urandom_range(0, 9);
            if (r <= 4)
                a = 32'h3000_0000 | (32'($urandom) & 32'h3FF);
            else if (r == 5)
                a = 32'h3000_0400 | 32'($urandom_range(0, 3));
            else if (r == 6 || r == 9)
                a = 32'h3000_0404;
            else if (r == 7)
                a = 32'h3000_0000 | (32'($urandom) & 32'h3FC);
            else
                a = 32'h3000_0408 + 32'(4 * $urandom_range(0, 765));
            wb_xfer(a, (r == 6 || r == 7), 32'($urandom), 4'($urandom), 0, 0, d, lat);
            if ($urandom_range(0, 3) == 0) mem[$urandom_range(0, 1023)] = 8'($urandom);
        end
        rand_fd = 0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
